// File: rtl/xmpl_dsp_pkg.sv
// Shared types and helpers for the DSP stage responders.
package xmpl_dsp_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stage_state_e;

  // Width that holds DEC summed DATA_W-bit signed samples without wrap.
  function automatic int acc_w(input int data_w, input int dec);
    return data_w + $clog2(dec);
  endfunction

endpackage

// File: rtl/xmpl_dsp_intdump.sv
// First-order integrate-and-dump decimator with valid/ready input and output.
module xmpl_dsp_intdump
  import xmpl_dsp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEC    = 8,
  parameter int ACC_W  = acc_w(DATA_W, DEC)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clr_i,
  input  logic                     run_i,
  input  logic                     smp_vld_i,
  input  logic signed [DATA_W-1:0] smp_dat_i,
  output logic                     smp_rdy_o,
  output logic                     out_vld_o,
  output logic signed [ACC_W-1:0]  out_dat_o,
  input  logic                     out_rdy_i,
  output logic                     out_fire_o
);

  localparam int DEC_W = $clog2(DEC);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] smp_ext;
  logic signed [ACC_W-1:0] sum;
  logic [DEC_W-1:0]        dec_cnt;
  logic                    accept;
  logic                    last;

  assign smp_rdy_o  = run_i & ~out_vld_o;
  assign accept     = smp_vld_i & smp_rdy_o;
  assign out_fire_o = out_vld_o & out_rdy_i;
  assign smp_ext    = {{(ACC_W-DATA_W){smp_dat_i[DATA_W-1]}}, smp_dat_i};
  assign sum        = acc + smp_ext;
  assign last       = (dec_cnt == DEC_W'(DEC - 1));

  // Accumulate accepted samples, dump the sum every DEC samples and hold it until taken.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc       <= '0;
      dec_cnt   <= '0;
      out_vld_o <= 1'b0;
      out_dat_o <= '0;
    end else if (clr_i) begin
      acc       <= '0;
      dec_cnt   <= '0;
      out_vld_o <= 1'b0;
      out_dat_o <= '0;
    end else if (accept) begin
      if (last) begin
        out_dat_o <= sum;
        out_vld_o <= 1'b1;
        acc       <= '0;
        dec_cnt   <= '0;
      end else begin
        acc     <= sum;
        dec_cnt <= dec_cnt + 1'b1;
      end
    end else if (out_fire_o) begin
      out_vld_o <= 1'b0;
    end
  end

endmodule

// File: rtl/xmpl_dsp_stage_rsp.sv
// Responder for one enable/status slot: runs one decimated frame per enable.
module xmpl_dsp_stage_rsp
  import xmpl_dsp_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEC       = 8,
  parameter int FRAME_LEN = 64,
  localparam int ACC_W    = acc_w(DATA_W, DEC)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  output logic                     status_o,
  output logic                     busy_o,
  output logic [STATE_W-1:0]       state_o,
  input  logic                     smp_vld_i,
  input  logic signed [DATA_W-1:0] smp_dat_i,
  output logic                     smp_rdy_o,
  output logic                     out_vld_o,
  output logic signed [ACC_W-1:0]  out_dat_o,
  input  logic                     out_rdy_i
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  stage_state_e     state;
  stage_state_e     state_nxt;
  logic [CNT_W-1:0] out_cnt;
  logic             out_fire;
  logic             run;
  logic             clr;
  logic             frame_end;

  assign run       = (state == ST_RUN);
  assign clr       = ~run | ~en_i;
  assign frame_end = out_fire & (out_cnt == CNT_W'(FRAME_LEN - 1));
  assign busy_o    = run;
  assign status_o  = (state == ST_DONE);
  assign state_o   = state;

  xmpl_dsp_intdump #(
    .DATA_W(DATA_W),
    .DEC   (DEC),
    .ACC_W (ACC_W)
  ) u_intdump (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (clr),
    .run_i     (run),
    .smp_vld_i (smp_vld_i),
    .smp_dat_i (smp_dat_i),
    .smp_rdy_o (smp_rdy_o),
    .out_vld_o (out_vld_o),
    .out_dat_o (out_dat_o),
    .out_rdy_i (out_rdy_i),
    .out_fire_o(out_fire)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next state; dropping enable always wins, including over the final handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en_i) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!en_i)          state_nxt = ST_IDLE;
        else if (frame_end) state_nxt = ST_DONE;
      end
      ST_DONE: if (!en_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Count completed output handshakes within the current frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)    out_cnt <= '0;
    else if (!run)     out_cnt <= '0;
    else if (out_fire) out_cnt <= out_cnt + 1'b1;
  end

endmodule

// File: tb/tb_xmpl_dsp_stage_rsp.sv
// Directed self-checking bench for xmpl_dsp_stage_rsp (DEC=8, FRAME_LEN=4).
module tb_xmpl_dsp_stage_rsp;

  localparam int DATA_W    = 16;
  localparam int DEC       = 8;
  localparam int FRAME_LEN = 4;
  localparam int ACC_W     = 19;

  logic                     clk_i;
  logic                     reset_n_i;
  logic                     en_i;
  logic                     status_o;
  logic                     busy_o;
  logic [1:0]               state_o;
  logic                     smp_vld_i;
  logic signed [DATA_W-1:0] smp_dat_i;
  logic                     smp_rdy_o;
  logic                     out_vld_o;
  logic signed [ACC_W-1:0]  out_dat_o;
  logic                     out_rdy_i;

  int checkCount = 0;
  int errorCount = 0;
  int gotOut[$];
  int nomExp[4] = '{36, 100, 164, 228};

  xmpl_dsp_stage_rsp #(
    .DATA_W   (DATA_W),
    .DEC      (DEC),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en_i     (en_i),
    .status_o (status_o),
    .busy_o   (busy_o),
    .state_o  (state_o),
    .smp_vld_i(smp_vld_i),
    .smp_dat_i(smp_dat_i),
    .smp_rdy_o(smp_rdy_o),
    .out_vld_o(out_vld_o),
    .out_dat_o(out_dat_o),
    .out_rdy_i(out_rdy_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Runs one enabled frame of 32 samples from IDLE, optionally stalling the first output.
  task automatic applyStimulus(input bit negMode, input int stallCycles);
    int  idx       = 0;
    int  stallLeft = stallCycles;
    bit  expectVld = 1'b0;
    bit  done      = 1'b0;
    int  firstVal  = negMode ? -262144 : 36;
    gotOut.delete();
    en_i      = 1'b1;
    smp_vld_i = 1'b0;
    out_rdy_i = 1'b1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(posedge clk_i); #1;
      if (expectVld) begin
        checkOutput("dump_latency", out_vld_o, 1);
        expectVld = 1'b0;
      end
      if (gotOut.size() == FRAME_LEN) begin
        checkOutput("status_rise", status_o, 1);
        checkOutput("busy_done", busy_o, 0);
        checkOutput("state_done", state_o, 2);
        checkOutput("rdy_done", smp_rdy_o, 0);
        done = 1'b1;
      end else begin
        smp_vld_i = (idx < 32);
        smp_dat_i = negMode ? -16'sd32768 : DATA_W'(idx + 1);
        if (out_vld_o) begin
          if (stallLeft > 0) begin
            out_rdy_i = 1'b0;
            stallLeft--;
            checkOutput("bp_hold_dat", out_dat_o, firstVal);
            checkOutput("bp_rdy_low", smp_rdy_o, 0);
          end else begin
            out_rdy_i = 1'b1;
            gotOut.push_back(int'(out_dat_o));
          end
        end else begin
          out_rdy_i = 1'b1;
        end
        if (smp_vld_i && smp_rdy_o) begin
          idx++;
          if (idx % DEC == 0) expectVld = 1'b1;
        end
      end
    end
    smp_vld_i = 1'b0;
    if (!done) checkOutput("frame_timeout", 0, 1);
  endtask

  // Drop enable from DONE and confirm the return to IDLE.
  task automatic releaseEnable();
    en_i = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("release_status", status_o, 0);
    checkOutput("release_state", state_o, 0);
  endtask

  initial begin
    int idx;
    int outCnt;
    bit statusSeen;

    reset_n_i = 1'b0;
    en_i      = 1'b0;
    smp_vld_i = 1'b0;
    smp_dat_i = '0;
    out_rdy_i = 1'b0;
    #2;
    checkOutput("rst_status", status_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_smp_rdy", smp_rdy_o, 0);
    checkOutput("rst_out_vld", out_vld_o, 0);
    checkOutput("rst_out_dat", out_dat_o, 0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] nominal frame");
    applyStimulus(1'b0, 0);
    for (int i = 0; i < gotOut.size() && i < 4; i++) checkOutput("nom_out", gotOut[i], nomExp[i]);
    checkOutput("nom_count", gotOut.size(), 4);

    $display("[TB] release after done");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checkOutput("hold_status", status_o, 1);
      checkOutput("hold_state", state_o, 2);
    end
    releaseEnable();

    $display("[TB] negative extreme");
    applyStimulus(1'b1, 0);
    for (int i = 0; i < gotOut.size() && i < 4; i++) checkOutput("neg_out", gotOut[i], -262144);
    checkOutput("neg_count", gotOut.size(), 4);
    releaseEnable();

    $display("[TB] backpressure");
    applyStimulus(1'b0, 5);
    for (int i = 0; i < gotOut.size() && i < 4; i++) checkOutput("bp_out", gotOut[i], nomExp[i]);
    checkOutput("bp_count", gotOut.size(), 4);
    releaseEnable();

    $display("[TB] abort");
    en_i       = 1'b1;
    out_rdy_i  = 1'b1;
    idx        = 0;
    outCnt     = 0;
    statusSeen = 1'b0;
    for (int cyc = 0; cyc < 100 && idx < 12; cyc++) begin
      @(posedge clk_i); #1;
      if (status_o) statusSeen = 1'b1;
      smp_vld_i = 1'b1;
      smp_dat_i = DATA_W'(idx + 1);
      if (out_vld_o) outCnt++;
      if (smp_vld_i && smp_rdy_o) idx++;
    end
    if (idx < 12) checkOutput("abort_timeout", idx, 12);
    @(posedge clk_i); #1;
    en_i      = 1'b0;
    smp_vld_i = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("abort_state", state_o, 0);
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_out_vld", out_vld_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      if (status_o) statusSeen = 1'b1;
      if (out_vld_o) outCnt++;
    end
    checkOutput("abort_outputs", outCnt, 1);
    checkOutput("abort_status_never", statusSeen, 0);
    applyStimulus(1'b0, 0);
    for (int i = 0; i < gotOut.size() && i < 4; i++) checkOutput("reen_out", gotOut[i], nomExp[i]);
    checkOutput("reen_count", gotOut.size(), 4);
    releaseEnable();

    $display("[TB] reset mid-run");
    en_i      = 1'b1;
    out_rdy_i = 1'b0;
    idx       = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk_i); #1;
      if (out_vld_o) break;
      smp_vld_i = 1'b1;
      smp_dat_i = DATA_W'(idx + 1);
      if (smp_vld_i && smp_rdy_o) idx++;
    end
    smp_vld_i = 1'b0;
    checkOutput("pre_reset_vld", out_vld_o, 1);
    checkOutput("pre_reset_dat", out_dat_o, 36);
    #2;
    reset_n_i = 1'b0;
    #1;
    checkOutput("mid_rst_out_vld", out_vld_o, 0);
    checkOutput("mid_rst_out_dat", out_dat_o, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_state", state_o, 0);
    checkOutput("mid_rst_smp_rdy", smp_rdy_o, 0);
    checkOutput("mid_rst_status", status_o, 0);
    en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    applyStimulus(1'b0, 0);
    for (int i = 0; i < gotOut.size() && i < 4; i++) checkOutput("post_rst_out", gotOut[i], nomExp[i]);
    checkOutput("post_rst_count", gotOut.size(), 4);
    releaseEnable();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
